// File: rtl/spirose_pkg.sv
// Shared definitions for the SpiRose slice RAM path: slice geometry, RGB565 layout, writer states.
// Latency: n/a (package only).
// Backpressure: n/a.
package spirose_pkg;

    localparam int ROW_SIZE    = 40;
    localparam int COLUMN_SIZE = 48;
    localparam int IMAGE_SIZE  = ROW_SIZE * COLUMN_SIZE;

    // RGB565 field offsets; the framebuffer colour decode relies on the same layout.
    localparam int RGB565_B_OFS = 0;
    localparam int RGB565_G_OFS = 5;
    localparam int RGB565_R_OFS = 11;

    typedef enum logic [1:0] {
        SYNC,
        FILL,
        RUN
    } wr_state_t;

endpackage

// File: rtl/rgb888_to_rgb565.sv
// Packs an RGB888 pixel into RGB565 by truncating each channel to its MSBs.
// Latency: 1 cycle (registered output).
// Backpressure: none; accepts a new pixel every cycle.
// Ports: clk/rst_n, rgb (R[23:16] G[15:8] B[7:0]) in, rgb565 out.
module rgb888_to_rgb565
    import spirose_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] rgb,
    output logic [15:0] rgb565
);

    logic [15:0] rgb565_d;
    logic [15:0] rgb565_q;
    logic        unused_lsbs;

    always_comb begin
        rgb565_d                      = '0;
        rgb565_d[RGB565_R_OFS +: 5]   = rgb[23:19];
        rgb565_d[RGB565_G_OFS +: 6]   = rgb[15:10];
        rgb565_d[RGB565_B_OFS +: 5]   = rgb[7:3];
    end

    // Dropped channel LSBs are intentionally discarded.
    assign unused_lsbs = ^{rgb[18:16], rgb[9:8], rgb[2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb565_q <= '0;
        end else begin
            rgb565_q <= rgb565_d;
        end
    end

    assign rgb565 = rgb565_q;

endmodule

// File: rtl/rgb_ram_writer.sv
// Writes the parallel RGB888 video stream, packed to RGB565, sequentially into the slice RAM from RAM_BASE.
// Latency: a pixel sampled at edge n is presented on the RAM write port after edge n+2.
// Backpressure: none; one write per cycle sustained, the RAM must accept every write.
// Ports: clk_33/nrst; rgb/de/vsync video in; ram_addr/ram_data/ram_we write port; stream, frame_error status.
module rgb_ram_writer
    import spirose_pkg::*;
#(
    parameter int          RAM_ADDR_WIDTH = 32,
    parameter int          RAM_DATA_WIDTH = 16,
    parameter int unsigned RAM_BASE       = 0,
    parameter int          SLICES_IN_RAM  = 18,
    parameter int          ROW_SIZE       = spirose_pkg::ROW_SIZE,
    parameter int          COLUMN_SIZE    = spirose_pkg::COLUMN_SIZE
) (
    input  logic                      clk_33,
    input  logic                      nrst,
    input  logic [23:0]               rgb,
    input  logic                      de,
    input  logic                      vsync,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_DATA_WIDTH-1:0] ram_data,
    output logic                      ram_we,
    output logic                      stream,
    output logic                      frame_error
);

    localparam int IMAGE_SIZE   = ROW_SIZE * COLUMN_SIZE;
    localparam int FRAME_PIXELS = IMAGE_SIZE * SLICES_IN_RAM;
    localparam int CNT_W        = $clog2(FRAME_PIXELS + 1);

    localparam logic [CNT_W-1:0]          CNT_FULL  = CNT_W'(FRAME_PIXELS);
    localparam logic [RAM_ADDR_WIDTH-1:0] BASE_ADDR = RAM_ADDR_WIDTH'(RAM_BASE);

    // Input stage
    logic [23:0] rgb_d, rgb_q;
    logic        de_d, de_q;
    logic        vsync_d, vsync_q;
    logic        vsync_prev_d, vsync_prev_q;

    // Control stage, aligned with the packer output
    wr_state_t                 state_d, state_q;
    logic [CNT_W-1:0]          pix_cnt_d, pix_cnt_q;
    logic                      ovf_d, ovf_q;
    logic                      err_d, err_q;
    logic                      we_d, we_q;
    logic [RAM_ADDR_WIDTH-1:0] wr_addr_d, wr_addr_q;

    // Output stage
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_d, ram_addr_q;
    logic [RAM_DATA_WIDTH-1:0] ram_data_d, ram_data_q;
    logic                      ram_we_d, ram_we_q;
    logic                      stream_d, stream_q;

    logic [15:0] pix565;
    logic        vsync_edge;
    logic        accept;

    rgb888_to_rgb565 u_pack (
        .clk    (clk_33),
        .rst_n  (nrst),
        .rgb    (rgb_q),
        .rgb565 (pix565)
    );

    assign vsync_edge = vsync_q & ~vsync_prev_q;
    // de is masked while vsync is high, so an edge and a pixel never share a cycle.
    assign accept     = de_q & ~vsync_q & (state_q != SYNC);

    always_comb begin
        rgb_d        = rgb;
        de_d         = de;
        vsync_d      = vsync;
        vsync_prev_d = vsync_q;

        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        ovf_d     = ovf_q;
        err_d     = 1'b0;
        we_d      = 1'b0;
        wr_addr_d = wr_addr_q;

        if (vsync_edge) begin
            pix_cnt_d = '0;
            ovf_d     = 1'b0;
            case (state_q)
                SYNC:    state_d = FILL;
                FILL:    err_d   = (pix_cnt_q != CNT_FULL);
                RUN: begin
                    if (pix_cnt_q != CNT_FULL) begin
                        err_d   = 1'b1;
                        state_d = FILL;
                    end
                end
                default: state_d = SYNC;
            endcase
        end else if (accept) begin
            if (pix_cnt_q == CNT_FULL) begin
                // Excess pixels are dropped; flag the frame only once.
                if (!ovf_q) begin
                    err_d = 1'b1;
                    ovf_d = 1'b1;
                end
            end else begin
                we_d      = 1'b1;
                wr_addr_d = BASE_ADDR + RAM_ADDR_WIDTH'(pix_cnt_q);
                pix_cnt_d = pix_cnt_q + CNT_W'(1);
                if (state_q == FILL && pix_cnt_d == CNT_FULL) begin
                    state_d = RUN;
                end
            end
        end

        ram_addr_d = wr_addr_q;
        ram_data_d = RAM_DATA_WIDTH'(pix565);
        ram_we_d   = we_q;
        // Sampled one stage late so it rises with the last write of the first frame.
        stream_d   = (state_q == RUN);
    end

    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            rgb_q        <= '0;
            de_q         <= 1'b0;
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            state_q      <= SYNC;
            pix_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            we_q         <= 1'b0;
            wr_addr_q    <= BASE_ADDR;
            ram_addr_q   <= BASE_ADDR;
            ram_data_q   <= '0;
            ram_we_q     <= 1'b0;
            stream_q     <= 1'b0;
        end else begin
            rgb_q        <= rgb_d;
            de_q         <= de_d;
            vsync_q      <= vsync_d;
            vsync_prev_q <= vsync_prev_d;
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            we_q         <= we_d;
            wr_addr_q    <= wr_addr_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            ram_we_q     <= ram_we_d;
            stream_q     <= stream_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_data    = ram_data_q;
    assign ram_we      = ram_we_q;
    assign stream      = stream_q;
    assign frame_error = err_q;

endmodule
